keypad_scan_fifo: RTL and testbench
===================================

// Module: keypad_scan_fifo
// PURPOSE
//  Parametrised matrix-keypad scanner: drives one-cold rows, decodes a single pressed key per scan
//  frame and debounces it over whole frames. Accepted presses (and optional auto-repeats) are queued
//  in a FIFO. Sits on the CPU I/O bus: the CPU polls status, pops codes and clears overflow.
// PARAMETERS
//  ROWS           4      number of keypad rows driven (>=2)
//  COLS           4      number of keypad columns read (>=2)
//  SCAN_DIV       16384  clk cycles per row step (>=2)
//  DEBOUNCE_SCANS 8      consecutive identical frames needed to accept a press or a release (>=1)
//  REPEAT_SCANS   0      frames between auto-repeat pushes while held; 0 = auto-repeat off
//  FIFO_DEPTH     8      key-code queue depth (power of 2, 2..128)
// PORTS
//  clk       in   1               system clock
//  rst       in   1               synchronous reset, active high
//  rowwrite  out  ROWS            row drive, active low, exactly one bit low
//  colread   in   COLS            column sense, active low, already synchronised externally
//  addr      in   2               0 = key data, 1 = status, 2-3 = read as 0
//  rd        in   1               read strobe; a pop happens when rd=1, addr=0 and FIFO non-empty
//  clr_ovf   in   1               clears the sticky overflow flag
//  data_out  out  16              combinational read data, selected by addr
// BEHAVIOUR
//  Reset: rowwrite = ~1 (row 0 low); divider, frame and debounce counters = 0; FIFO empty;
//   overflow = 0; FSM = IDLE. data_out reads 0 for every addr.
//  Row tick: fires when the divider reaches SCAN_DIV-1; the divider then wraps to 0.
//   On each tick, colread is sampled for the current row, then rowwrite rotates to the next row
//   (row ROWS-1 wraps to row 0). One frame = ROWS ticks; the frame result is evaluated on the tick
//   that samples row ROWS-1.
//  Frame result:
//   - exactly one low column across the whole frame -> KEY with code = row*COLS+col
//     (KW = clog2(ROWS*COLS) bits);
//   - no low column -> NONE;
//   - two or more low bits -> GHOST, handled exactly as NONE.
//  FSM, advanced once per frame. cnt counts frames:
//   - IDLE: on KEY, latch cand = code, cnt = 1, go to DEB.
//   - DEB: KEY with the same code -> cnt++. KEY with a different code -> cand = code, cnt = 1.
//     NONE -> IDLE. When cnt reaches DEBOUNCE_SCANS: push cand, cnt = 0, go to HELD.
//   - HELD: KEY with the same code -> if REPEAT_SCANS != 0, cnt++; at REPEAT_SCANS push cand and
//     set cnt = 0. Any other result -> cnt = 0, go to REL.
//   - REL: NONE increments cnt; at DEBOUNCE_SCANS go to IDLE. KEY with the same code -> back to
//     HELD, no push. KEY with a different code -> cand = code, cnt = 1, go to DEB.
//  Latency: a clean press is pushed on the DEBOUNCE_SCANS-th frame end after first detection.
//   It is visible in the status word on the next clk.
//  FIFO:
//   - push writes at the tail; pop advances the head on posedge clk.
//   - push while full: code dropped, overflow <= 1. If a pop happens in the same cycle, the push
//     is accepted instead.
//   - pop while empty: no effect.
//   - overflow is sticky. clr_ovf clears it; if a set and a clear occur in the same cycle, set wins.
//  data_out:
//   - addr 0: {zeros, head code} when non-empty, else 0.
//   - addr 1: [15:8] = count (0..FIFO_DEPTH), [2] = overflow, [1] = full, [0] = non-empty, other bits 0.
//  Reset during a scan or debounce sequence discards the candidate and all queued codes.
// TESTING
//  (sim params: ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE_SCANS=3, FIFO_DEPTH=4)
//  1 reset -> rowwrite=4'b1110; addr1 reads 16'h0000; row steps every 4 clk: 1101, 1011, 0111, 1110
//  2 hold row2/col1 for 3 frames -> status 16'h0101, addr0 reads 16'h0009; rd pop -> status 16'h0000
//  3 bounce: key 5 present 2 frames, absent 1, present 2 -> nothing pushed; then a 3rd frame -> one push
//  4 two keys low in the same frame, held 10 frames -> no push; release one -> remaining key pushed
//  5 5 distinct presses, no pops -> status 16'h0407 (count 4, full, ovf); clr_ovf -> 16'h0403; 4 pops -> 0
//  6 REPEAT_SCANS=2, hold key 3 for 9 frames -> 4 pushes total (3 at frames 5, 7, 9 after first);
//    rst mid-hold -> empty, IDLE

Source files
------------

// File: rtl/keypad_scan_fifo.sv
// keypad_scan_fifo: matrix-keypad scanner with frame-level debounce,
// optional auto-repeat and a key-code FIFO read over a small CPU bus.
module keypad_scan_fifo #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIV       = 16384,
  parameter int DEBOUNCE_SCANS = 8,
  parameter int REPEAT_SCANS   = 0,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic            clk,
  input  logic            rst,
  output logic [ROWS-1:0] rowwrite,
  input  logic [COLS-1:0] colread,
  input  logic [1:0]      addr,
  input  logic            rd,
  input  logic            clr_ovf,
  output logic [15:0]     data_out
);

  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int KW   = $clog2(ROWS * COLS);
  localparam int DW   = $clog2(SCAN_DIV);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int PW   = AW + 1;
  localparam int CMAX = (DEBOUNCE_SCANS > REPEAT_SCANS) ? DEBOUNCE_SCANS : REPEAT_SCANS;
  localparam int NW   = $clog2(CMAX + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [NW-1:0] DEB_C    = NW'(DEBOUNCE_SCANS);
  localparam logic [NW-1:0] REP_C    = NW'(REPEAT_SCANS);
  localparam logic [PW-1:0] DEPTH_C  = PW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DEB  = 2'd1;
  localparam logic [1:0] S_HELD = 2'd2;
  localparam logic [1:0] S_REL  = 2'd3;

  // Low-column tally that saturates at 2: anything beyond one key is a ghost.
  function automatic logic [1:0] sat_cnt(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > 3'd2) ? 2'd2 : s[1:0];
  endfunction

  logic [DW-1:0] r_div;
  logic [RW-1:0] r_row;
  logic [1:0]    r_acc_n;
  logic [KW-1:0] r_acc_code;
  logic [1:0]    r_state;
  logic [NW-1:0] r_cnt;
  logic [KW-1:0] r_cand;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic          r_ovf;
  logic [KW-1:0] r_mem [FIFO_DEPTH];

  logic          w_tick, w_last, w_frame, w_key, w_same, w_start, w_push;
  logic [ROWS-1:0] w_rowsel;
  logic [COLS-1:0] w_low;
  logic [1:0]    w_row_n, w_frame_n;
  logic [CW-1:0] w_col;
  logic [KW-1:0] w_row_code, w_frame_code, w_cand_nx;
  logic [1:0]    w_state_nx;
  logic [NW-1:0] w_cnt_nx, w_cnt_inc;
  logic [PW-1:0] w_count;
  logic          w_empty, w_full, w_pop, w_push_ok, w_ovf_set;

  assign w_tick  = (r_div == DIV_LAST);
  assign w_last  = (r_row == ROW_LAST);
  assign w_frame = w_tick && w_last;

  // Row-step divider.
  always_ff @(posedge clk) begin
    if (rst)         r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + 1'b1;
  end

  // Active row index, rotating once per tick.
  always_ff @(posedge clk) begin
    if (rst)         r_row <= '0;
    else if (w_tick) r_row <= w_last ? '0 : r_row + 1'b1;
  end

  // One-cold row drive decoded from the row index.
  always_comb begin
    for (int r = 0; r < ROWS; r++) w_rowsel[r] = (r_row == RW'(r));
    rowwrite = ~w_rowsel;
  end

  // Decode the current row's columns into a saturated count and the column of the last low bit.
  always_comb begin
    w_low   = ~colread;
    w_row_n = 2'd0;
    w_col   = '0;
    for (int c = 0; c < COLS; c++) begin
      if (w_low[c]) begin
        w_row_n = sat_cnt(w_row_n, 2'd1);
        w_col   = CW'(c);
      end
    end
    w_row_code   = KW'(int'(r_row) * COLS + int'(w_col));
    w_frame_n    = sat_cnt(r_acc_n, w_row_n);
    w_frame_code = (w_row_n == 2'd1) ? w_row_code : r_acc_code;
    w_key        = (w_frame_n == 2'd1);
  end

  // Frame accumulator: cleared at each frame end, code is only meaningful when count is 1.
  always_ff @(posedge clk) begin
    if (rst)         r_acc_n <= 2'd0;
    else if (w_tick) r_acc_n <= w_last ? 2'd0 : w_frame_n;
  end

  // Accumulated code follows the tally without reset.
  always_ff @(posedge clk) begin
    if (w_tick) r_acc_code <= w_frame_code;
  end

  // Debounce / repeat decision, evaluated only on frame ends.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_cand_nx  = r_cand;
    w_push     = 1'b0;
    w_start    = 1'b0;
    w_cnt_inc  = r_cnt + 1'b1;
    w_same     = (w_frame_code == r_cand);
    if (w_frame) begin
      case (r_state)
        S_IDLE: if (w_key) w_start = 1'b1;
        S_DEB: begin
          if (!w_key) begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
          end else if (!w_same) begin
            w_start = 1'b1;
          end else if (w_cnt_inc == DEB_C) begin
            w_push     = 1'b1;
            w_cnt_nx   = '0;
            w_state_nx = S_HELD;
          end else begin
            w_cnt_nx = w_cnt_inc;
          end
        end
        S_HELD: begin
          if (w_key && w_same) begin
            if (REPEAT_SCANS != 0) begin
              if (w_cnt_inc == REP_C) begin
                w_push   = 1'b1;
                w_cnt_nx = '0;
              end else begin
                w_cnt_nx = w_cnt_inc;
              end
            end
          end else begin
            w_cnt_nx   = '0;
            w_state_nx = S_REL;
          end
        end
        default: begin
          if (!w_key) begin
            if (w_cnt_inc == DEB_C) begin
              w_state_nx = S_IDLE;
              w_cnt_nx   = '0;
            end else begin
              w_cnt_nx = w_cnt_inc;
            end
          end else if (w_same) begin
            w_state_nx = S_HELD;
            w_cnt_nx   = '0;
          end else begin
            w_start = 1'b1;
          end
        end
      endcase
      // A new candidate counts its first frame immediately.
      if (w_start) begin
        w_cand_nx = w_frame_code;
        if (DEBOUNCE_SCANS == 1) begin
          w_push     = 1'b1;
          w_cnt_nx   = '0;
          w_state_nx = S_HELD;
        end else begin
          w_cnt_nx   = NW'(1);
          w_state_nx = S_DEB;
        end
      end
    end
  end

  // Debounce state and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Candidate code; irrelevant while idle, so it carries no reset.
  always_ff @(posedge clk) begin
    r_cand <= w_cand_nx;
  end

  assign w_count   = r_tail - r_head;
  assign w_empty   = (w_count == '0);
  assign w_full    = (w_count == DEPTH_C);
  assign w_pop     = rd && (addr == 2'd0) && !w_empty;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;

  // FIFO pointers; the extra MSB separates full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_push_ok) r_tail <= r_tail + 1'b1;
      if (w_pop)     r_head <= r_head + 1'b1;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_tail[AW-1:0]] <= w_cand_nx;
  end

  // Sticky overflow; a new overflow beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)            r_ovf <= 1'b0;
    else if (w_ovf_set) r_ovf <= 1'b1;
    else if (clr_ovf)   r_ovf <= 1'b0;
  end

  // Bus read mux.
  always_comb begin
    data_out = '0;
    case (addr)
      2'd0:    if (!w_empty) data_out = 16'(r_mem[r_head[AW-1:0]]);
      2'd1:    data_out = {8'(w_count), 5'b00000, r_ovf, w_full, ~w_empty};
      default: data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Bench for keypad_scan_fifo: scripted vectors, hand sequences and random
// traffic, all checked against a frame/queue level reference model.
module tb_keypad_scan_fifo;

  localparam int DEB = 3;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  colread;
  logic [1:0]  addr = 2'd0;
  logic        rd = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [3:0]  rowwrite_a, rowwrite_b;
  logic [15:0] dout_a, dout_b;
  logic [15:0] pressed = 16'h0000;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  keypad_scan_fifo #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(DEB),
                     .REPEAT_SCANS(0), .FIFO_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst(rst), .rowwrite(rowwrite_a), .colread(colread), .addr(addr),
    .rd(rd), .clr_ovf(clr_ovf), .data_out(dout_a));

  keypad_scan_fifo #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(DEB),
                     .REPEAT_SCANS(2), .FIFO_DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst(rst), .rowwrite(rowwrite_b), .colread(colread), .addr(addr),
    .rd(rd), .clr_ovf(clr_ovf), .data_out(dout_b));

  // Physical keypad: a pressed key pulls its column low while its row is driven.
  always_comb begin
    colread = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!rowwrite_a[r])
        for (int c = 0; c < 4; c++)
          if (pressed[r*4+c]) colread[c] = 1'b0;
  end

  // ---------------- reference model ----------------
  typedef struct {
    int held;       // accepted key still considered down, -1 if none
    bit releasing;  // accepted key went away, waiting for quiet frames
    int cand;       // key being debounced
    int progress;   // consecutive frames of cand toward acceptance
    int since;      // frames since last push while held
    int quiet;      // qualifying release frames
  } trk_t;

  trk_t trk_a, trk_b;
  int   mcyc, mrow;
  logic [15:0] seen;
  int   fq [2][DEPTH];
  int   fn [2];
  bit   ov [2];

  function automatic int frame_result(input logic [15:0] s);
    int n, idx;
    n = 0; idx = -1;
    for (int i = 0; i < 16; i++) if (s[i]) begin n++; idx = i; end
    return (n == 1) ? idx : -1;
  endfunction

  function automatic void track(inout trk_t t, input int res, input int rep, output int push);
    push = -1;
    if (t.held < 0) begin
      if (res >= 0) begin
        if (t.progress > 0 && res == t.cand) t.progress++;
        else begin t.cand = res; t.progress = 1; end
      end else t.progress = 0;
    end else if (!t.releasing) begin
      if (res == t.held) begin
        if (rep > 0) begin
          t.since++;
          if (t.since == rep) begin push = t.held; t.since = 0; end
        end
      end else begin t.releasing = 1; t.quiet = 0; end
    end else begin
      if (res < 0) begin
        t.quiet++;
        if (t.quiet == DEB) begin t.held = -1; t.releasing = 0; end
      end else if (res == t.held) begin
        t.releasing = 0; t.since = 0;
      end else begin
        t.held = -1; t.releasing = 0; t.cand = res; t.progress = 1;
      end
    end
    if (t.held < 0 && t.progress == DEB) begin
      push = t.cand; t.held = t.cand; t.releasing = 0; t.since = 0; t.progress = 0;
    end
  endfunction

  function automatic void trk_clear(output trk_t t);
    t.held = -1; t.releasing = 0; t.cand = 0; t.progress = 0; t.since = 0; t.quiet = 0;
  endfunction

  task automatic model_edge();
    int pu [2];
    bit pop, was_full, set;
    if (rst) begin
      mcyc = 0; mrow = 0; seen = '0;
      trk_clear(trk_a); trk_clear(trk_b);
      fn[0] = 0; fn[1] = 0; ov[0] = 0; ov[1] = 0;
      return;
    end
    mcyc++;
    pu[0] = -1; pu[1] = -1;
    if (mcyc % 4 == 0) begin
      seen = seen | (pressed & (16'h000F << (4 * mrow)));
      if (mrow == 3) begin
        track(trk_a, frame_result(seen), 0, pu[0]);
        track(trk_b, frame_result(seen), 2, pu[1]);
        seen = '0;
      end
      mrow = (mrow + 1) % 4;
    end
    for (int i = 0; i < 2; i++) begin
      pop = rd && (addr == 2'd0) && (fn[i] > 0);
      was_full = (fn[i] == DEPTH);
      set = 0;
      if (pop) begin
        for (int k = 0; k < DEPTH - 1; k++) fq[i][k] = fq[i][k+1];
        fn[i]--;
      end
      if (pu[i] >= 0) begin
        if (!was_full || pop) begin fq[i][fn[i]] = pu[i]; fn[i]++; end
        else set = 1;
      end
      if (set) ov[i] = 1;
      else if (clr_ovf) ov[i] = 0;
    end
  endtask

  function automatic logic [15:0] exp_dout(input int i, input logic [1:0] a);
    logic [15:0] v;
    v = '0;
    if (a == 2'd0 && fn[i] > 0) v = 16'(fq[i][0]);
    if (a == 2'd1) v = {8'(fn[i]), 5'b00000, ov[i], (fn[i] == DEPTH), (fn[i] > 0)};
    return v;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc1();
    logic [3:0] one4;
    one4 = 4'b0001;
    @(posedge clk);
    model_edge();
    #1;
    check("rowwrite_a", {12'h0, rowwrite_a}, {12'h0, ~(one4 << mrow)});
    check("rowwrite_b", {12'h0, rowwrite_b}, {12'h0, ~(one4 << mrow)});
    check("dout_a", dout_a, exp_dout(0, addr));
    check("dout_b", dout_b, exp_dout(1, addr));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc1();
    cyc1();
    rst = 1'b0;
  endtask

  task automatic align();
    while (mcyc % 16 != 0) cyc1();
  endtask

  typedef struct {
    logic [15:0] keys;
    int          frames;
    int          pops;
    bit          clr;
    bit          epop;   // pop on the frame-end edge that pushes
    logic [1:0]  addr;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic [15:0] k, input int f, input int p, input bit c,
                              input bit e, input logic [1:0] a, input logic [15:0] x);
    vec_t v;
    v.keys = k; v.frames = f; v.pops = p; v.clr = c; v.epop = e; v.addr = a; v.exp = x;
    vt.push_back(v);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  rseq [4];
    logic [15:0] one16;
    int          r;
    rseq[0] = 4'b1101; rseq[1] = 4'b1011; rseq[2] = 4'b0111; rseq[3] = 4'b1110;
    one16 = 16'h0001;

    // single press of row2/col1 (code 9), pop, release
    add(16'h0200, 3, 0, 0, 0, 2'd1, 16'h0101);
    add(16'h0200, 0, 0, 0, 0, 2'd0, 16'h0009);
    add(16'h0200, 0, 1, 0, 0, 2'd1, 16'h0000);
    add(16'h0000, 4, 0, 0, 0, 2'd1, 16'h0000);
    // bounce on key 5
    add(16'h0020, 2, 0, 0, 0, 2'd1, 16'h0000);
    add(16'h0000, 1, 0, 0, 0, 2'd1, 16'h0000);
    add(16'h0020, 2, 0, 0, 0, 2'd1, 16'h0000);
    add(16'h0020, 1, 0, 0, 0, 2'd1, 16'h0101);
    add(16'h0020, 0, 1, 0, 0, 2'd1, 16'h0000);
    add(16'h0000, 4, 0, 0, 0, 2'd1, 16'h0000);
    // ghost: keys 5 and 10 together, then only 10
    add(16'h0420, 10, 0, 0, 0, 2'd1, 16'h0000);
    add(16'h0400, 3, 0, 0, 0, 2'd1, 16'h0101);
    add(16'h0400, 0, 0, 0, 0, 2'd0, 16'h000A);
    add(16'h0400, 0, 1, 0, 0, 2'd1, 16'h0000);
    add(16'h0000, 4, 0, 0, 0, 2'd1, 16'h0000);
    // five presses, no pops -> overflow
    add(16'h0002, 3, 0, 0, 0, 2'd1, 16'h0101);
    add(16'h0000, 4, 0, 0, 0, 2'd1, 16'h0101);
    add(16'h0004, 3, 0, 0, 0, 2'd1, 16'h0201);
    add(16'h0000, 4, 0, 0, 0, 2'd1, 16'h0201);
    add(16'h0008, 3, 0, 0, 0, 2'd1, 16'h0301);
    add(16'h0000, 4, 0, 0, 0, 2'd1, 16'h0301);
    add(16'h0010, 3, 0, 0, 0, 2'd1, 16'h0403);
    add(16'h0000, 4, 0, 0, 0, 2'd1, 16'h0403);
    add(16'h0020, 3, 0, 0, 0, 2'd1, 16'h0407);
    add(16'h0000, 4, 0, 0, 0, 2'd1, 16'h0407);
    add(16'h0000, 0, 0, 1, 0, 2'd1, 16'h0403);
    add(16'h0000, 0, 0, 0, 0, 2'd0, 16'h0001);
    // push into a full FIFO on the same edge as a pop
    add(16'h0040, 3, 0, 0, 1, 2'd1, 16'h0403);
    add(16'h0040, 0, 0, 0, 0, 2'd0, 16'h0002);
    add(16'h0000, 4, 0, 0, 0, 2'd1, 16'h0403);
    add(16'h0000, 0, 4, 0, 0, 2'd1, 16'h0000);
    add(16'h0000, 0, 2, 0, 0, 2'd1, 16'h0000);

    // reset state and row rotation
    do_reset();
    addr = 2'd1; #1;
    check("rst_status", dout_a, 16'h0000);
    check("rst_row", {12'h0, rowwrite_a}, 16'h000E);
    addr = 2'd0; #1;
    check("rst_data", dout_a, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      repeat (4) cyc1();
      check($sformatf("row_step%0d", i), {12'h0, rowwrite_a}, {12'h0, rseq[i]});
    end

    // scripted vectors
    for (int i = 0; i < vt.size(); i++) begin
      pressed = vt[i].keys;
      repeat (vt[i].frames * 16 - (vt[i].epop ? 1 : 0)) cyc1();
      if (vt[i].epop) begin
        rd = 1'b1; addr = 2'd0; cyc1(); rd = 1'b0;
      end
      if (vt[i].pops > 0) begin
        rd = 1'b1; addr = 2'd0;
        repeat (vt[i].pops) cyc1();
        rd = 1'b0;
      end
      if (vt[i].clr) begin
        clr_ovf = 1'b1; cyc1(); clr_ovf = 1'b0;
      end
      align();
      addr = vt[i].addr; #1;
      check($sformatf("vec%0d", i), dout_a, vt[i].exp);
    end

    // auto-repeat on key 3, then reset in the middle of the hold
    pressed = 16'h0000;
    do_reset();
    addr = 2'd1;
    pressed = 16'h0008;
    for (int f = 1; f <= 9; f++) begin
      repeat (16) cyc1();
      if (f == 3) check("rep_f3", dout_b, 16'h0101);
      if (f == 5) check("rep_f5", dout_b, 16'h0201);
      if (f == 7) check("rep_f7", dout_b, 16'h0301);
      if (f == 9) check("rep_f9", dout_b, 16'h0403);
    end
    check("norep_a", dout_a, 16'h0101);
    repeat (7) cyc1();
    rst = 1'b1; cyc1(); rst = 1'b0;
    check("midrst_b", dout_b, 16'h0000);
    check("midrst_a", dout_a, 16'h0000);
    check("midrst_row", {12'h0, rowwrite_b}, 16'h000E);
    repeat (32) cyc1();
    check("after_rst_2f", dout_b, 16'h0000);
    repeat (16) cyc1();
    check("after_rst_3f", dout_b, 16'h0101);

    // random traffic against the model
    pressed = 16'h0000;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 47) == 0) begin
        r = $urandom_range(0, 5);
        if (r == 0) pressed = 16'h0000;
        else if (r == 1) pressed = (one16 << $urandom_range(0, 15)) | (one16 << $urandom_range(0, 15));
        else pressed = one16 << $urandom_range(0, 15);
      end
      rd      = ($urandom_range(0, 5) == 0);
      addr    = 2'($urandom_range(0, 3));
      clr_ovf = ($urandom_range(0, 40) == 0);
      cyc1();
    end
    rd = 1'b0; clr_ovf = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
